elevator_car_ctrl: RTL and testbench

Car motion controller on the consumer side of the floor-request sorter. It takes the sorter's `nextfloor` choice and empty flags, moves the car one floor per `TRAVEL_CYCLES`, then holds the doors open for `DOOR_CYCLES`. It drives `current_floor` back into the sorter, closing the request/position loop.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elev_tick_counter.sv | 27 ++
 rtl/elevator_car_ctrl.sv | 165 ++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the elevator car controller.
package elevator_pkg;

  localparam int FLOOR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOORS  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/elev_tick_counter.sv
// Modulo-N cycle counter with synchronous clear and terminal-count pulse.
module elev_tick_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  // tc is combinational so the owner can act on the same edge the count wraps
  assign o_tc = i_en && (r_cnt == L_LAST);

  // Count while enabled; wrap to 0 after the last count, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_clr || o_tc) r_cnt <= '0;
    else if (i_en)          r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car motion controller: takes the sorter's next floor, steps the car one
// floor per TRAVEL_CYCLES, holds doors open DOOR_CYCLES, feeds position back.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOOR_W       = FLOOR_W_DEF,
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int RESET_FLOOR   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOOR_W-1:0] nextfloor,
  input  logic               empthy_upward_reg,
  input  logic               empthy_downward_reg,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               arrived,
  output logic [FLOOR_W-1:0] served_floor,
  output logic               req_err
);

  localparam logic [FLOOR_W-1:0] L_NUM   = FLOOR_W'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] L_TOP   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] L_RESET = FLOOR_W'(RESET_FLOOR);

  state_t             r_state, w_state_nx;
  dir_t               r_dir, w_dir_nx;
  logic [FLOOR_W-1:0] r_target, w_target_nx;
  logic [FLOOR_W-1:0] r_floor, w_floor_nx;
  logic [FLOOR_W-1:0] r_served, w_served_nx;
  logic               r_up, w_up_nx;
  logic               r_dn, w_dn_nx;
  logic               r_door, w_door_nx;
  logic               r_arr, w_arr_nx;
  logic               r_err, w_err_nx;

  logic               w_pending;
  logic               w_tick_tc;
  logic               w_door_tc;
  logic [FLOOR_W-1:0] w_step;

  assign w_pending = !(empthy_upward_reg && empthy_downward_reg);
  assign w_step    = (r_dir == DIR_UP) ? r_floor + FLOOR_W'(1)
                                       : r_floor - FLOOR_W'(1);

  // Counters idle at 0 outside their state so each trip/door phase starts fresh
  elev_tick_counter #(.N(TRAVEL_CYCLES)) u_travel (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == MOVING),
    .i_clr (r_state != MOVING),
    .o_tc  (w_tick_tc)
  );

  elev_tick_counter #(.N(DOOR_CYCLES)) u_door (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == DOORS),
    .i_clr (r_state != DOORS),
    .o_tc  (w_door_tc)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_state_nx  = r_state;
    w_dir_nx    = r_dir;
    w_target_nx = r_target;
    w_floor_nx  = r_floor;
    w_served_nx = r_served;
    w_up_nx     = 1'b0;
    w_dn_nx     = 1'b0;
    w_door_nx   = 1'b0;
    w_arr_nx    = 1'b0;
    w_err_nx    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending) begin
          if (nextfloor >= L_NUM) begin
            w_err_nx = 1'b1;
          end else if (nextfloor == r_floor) begin
            w_state_nx  = DOORS;
            w_arr_nx    = 1'b1;
            w_door_nx   = 1'b1;
            w_served_nx = r_floor;
          end else begin
            w_state_nx  = MOVING;
            w_target_nx = nextfloor;
            w_dir_nx    = (nextfloor > r_floor) ? DIR_UP : DIR_DOWN;
            w_up_nx     = (nextfloor > r_floor);
            w_dn_nx     = (nextfloor < r_floor);
          end
        end
      end
      MOVING: begin
        w_up_nx = (r_dir == DIR_UP);
        w_dn_nx = (r_dir == DIR_DOWN);
        if (w_tick_tc) begin
          w_floor_nx = w_step;
          if (w_step == r_target) begin
            w_state_nx  = DOORS;
            w_arr_nx    = 1'b1;
            w_door_nx   = 1'b1;
            w_served_nx = w_step;
            w_up_nx     = 1'b0;
            w_dn_nx     = 1'b0;
          end
        end
      end
      DOORS: begin
        w_door_nx = 1'b1;
        if (w_door_tc) begin
          w_state_nx = IDLE;
          w_door_nx  = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State and output registers; reset abandons any trip or door cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dir    <= DIR_UP;
      r_target <= L_RESET;
      r_floor  <= L_RESET;
      r_served <= L_RESET;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_door   <= 1'b0;
      r_arr    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_dir    <= w_dir_nx;
      r_target <= w_target_nx;
      r_floor  <= w_floor_nx;
      r_served <= w_served_nx;
      r_up     <= w_up_nx;
      r_dn     <= w_dn_nx;
      r_door   <= w_door_nx;
      r_arr    <= w_arr_nx;
      r_err    <= w_err_nx;
    end
  end

  // Simulation guard: a step never leaves 0..NUM_FLOORS-1
  always @(posedge clk) begin
    if (!rst && r_state == MOVING && w_tick_tc)
      assert ((r_dir == DIR_UP) ? (r_floor < L_TOP) : (r_floor != '0));
  end

  assign current_floor = r_floor;
  assign served_floor  = r_served;
  assign moving_up     = r_up;
  assign moving_down   = r_dn;
  assign door_open     = r_door;
  assign arrived       = r_arr;
  assign req_err       = r_err;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Scoreboard bench for elevator_car_ctrl: stimulus pushes expected floor
// steps / arrivals / errors with their cycle; a negedge monitor pops them.
module tb_elevator_car_ctrl;

  localparam int TC = 4;
  localparam int DC = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nextfloor = '0;
  logic        eu = 1'b1, ed = 1'b1;
  logic [15:0] current_floor, served_floor;
  logic        moving_up, moving_down, door_open, arrived, req_err;

  elevator_car_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .nextfloor           (nextfloor),
    .empthy_upward_reg   (eu),
    .empthy_downward_reg (ed),
    .current_floor       (current_floor),
    .moving_up           (moving_up),
    .moving_down         (moving_down),
    .door_open           (door_open),
    .arrived             (arrived),
    .served_floor        (served_floor),
    .req_err             (req_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // kind: 0 floor step, 1 arrival, 2 request error
  typedef struct { int kind; int fl; int cy; } ev_t;
  ev_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int fl, input int cy);
    ev_t e;
    e.kind = kind; e.fl = fl; e.cy = cy;
    q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int fl);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d floor %0d, expected none (cycle %0d)", kind, fl, cyc);
    end else begin
      e = q.pop_front();
      check("ev_kind",  kind, e.kind);
      check("ev_floor", fl,   e.fl);
      check("ev_cycle", cyc,  e.cy);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks invariants
  logic [15:0] prev_fl = '0;
  int door_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_fl  = current_floor;
      door_run = 0;
    end else begin
      if (current_floor != prev_fl) sb_pop(0, int'(current_floor));
      if (arrived) begin
        sb_pop(1, int'(served_floor));
        check("door_at_arrival", int'(door_open), 1);
      end
      if (req_err) sb_pop(2, int'(current_floor));
      prev_fl = current_floor;
      if (door_open) door_run++;
      else if (door_run != 0) begin
        check("door_len", door_run, DC);
        door_run = 0;
      end
      check("dir_exclusive", int'(moving_up && moving_down), 0);
    end
  end

  // One complete trip (or same-floor service), called at a negedge
  task automatic trip(input int from, input int to);
    int d, e0, mv;
    bit up;
    up = (to > from);
    d  = up ? to - from : from - to;
    mv = 0;
    nextfloor = 16'(to); eu = 1'b0; ed = 1'b0;
    e0 = cyc + 1;
    for (int k = 1; k <= d; k++) push(0, up ? from + k : from - k, e0 + k * TC);
    push(1, to, e0 + d * TC);
    @(negedge clk);
    eu = 1'b1; ed = 1'b1;
    repeat (d * TC) begin
      mv += up ? int'(moving_up) : int'(moving_down);
      @(negedge clk);
    end
    if (d > 0) check("move_len", mv, d * TC);
    repeat (DC + 2) @(negedge clk);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_floor",  int'(current_floor), 0);
    check("rst_served", int'(served_floor), 0);
    check("rst_flags",  int'({moving_up, moving_down, door_open, arrived, req_err}), 0);
    @(negedge clk);
    repeat (50) @(negedge clk);
    check("idle_floor", int'(current_floor), 0);
    check("idle_flags", int'({moving_up, moving_down, door_open, arrived, req_err}), 0);

    trip(0, 3);
    check("served_3", int'(served_floor), 3);
    trip(3, 5);
    trip(5, 4);
    check("served_4", int'(served_floor), 4);
    trip(4, 2);
    trip(2, 2);
    check("same_floor", int'(current_floor), 2);

    // Out-of-range request held for two IDLE evaluations
    nextfloor = 16'd9; eu = 1'b0; ed = 1'b0;
    push(2, 2, cyc + 1);
    push(2, 2, cyc + 2);
    repeat (2) @(negedge clk);
    eu = 1'b1; ed = 1'b1;
    repeat (4) @(negedge clk);
    check("err_floor", int'(current_floor), 2);
    check("err_nomove", int'({moving_up, moving_down, door_open}), 0);

    trip(2, 0);

    // 0 -> 6 with nextfloor changed mid-trip, then reset during doors
    nextfloor = 16'd6; eu = 1'b0; ed = 1'b0;
    e0 = cyc + 1;
    for (int k = 1; k <= 6; k++) push(0, k, e0 + k * TC);
    push(1, 6, e0 + 6 * TC);
    @(negedge clk);
    repeat (4) @(negedge clk);
    nextfloor = 16'd1;
    repeat (6 * TC - 4 + 2) @(negedge clk);
    check("trip6_floor", int'(current_floor), 6);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_floor", int'(current_floor), 0);
    check("rst_mid_flags", int'({moving_up, moving_down, door_open, arrived, req_err}), 0);
    eu = 1'b1; ed = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_floor", int'(current_floor), 0);
    check("post_rst_idle", int'({moving_up, moving_down, door_open}), 0);
    check("sb_leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the flow above ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
